// File: rtl/mul_share_pkg.sv
// mul_share_pkg
// Shared constants and types for the time-shared multiplier scheduler.
//   CHAN_A / CHAN_X : channel tags carried with every product
//   DEPTH           : number of result buffer entries
//   CNT_W           : width of the buffer occupancy count (holds 0..DEPTH)
//   DEFAULT_N       : default operand/result width
//   entry_t         : one buffered result at the default width
package mul_share_pkg;

    localparam logic CHAN_A    = 1'b0;
    localparam logic CHAN_X    = 1'b1;
    localparam int   DEPTH     = 2;
    localparam int   CNT_W     = 2;
    localparam int   DEFAULT_N = 8;

    typedef struct packed {
        logic                 chan;
        logic [DEFAULT_N-1:0] data;
    } entry_t;

endpackage

// File: rtl/mul_share_sched_if.sv
// mul_share_sched_if
// Bundles the two request channels and the result channel of the scheduler.
//   a_valid/a_ready/a_op/b_op : channel A request handshake and operands
//   x_valid/x_ready/x_op/y_op : channel X request handshake and operands
//   p_valid/p_ready/p_data/p_chan : result handshake, product and source tag
// Modports:
//   slave  : the scheduler itself
//   master : requesters and result consumer
interface mul_share_sched_if #(
    parameter int N = 8
);

    logic         a_valid;
    logic         a_ready;
    logic [N-1:0] a_op;
    logic [N-1:0] b_op;

    logic         x_valid;
    logic         x_ready;
    logic [N-1:0] x_op;
    logic [N-1:0] y_op;

    logic         p_valid;
    logic         p_ready;
    logic [N-1:0] p_data;
    logic         p_chan;

    modport slave (
        input  a_valid, a_op, b_op,
        input  x_valid, x_op, y_op,
        input  p_ready,
        output a_ready, x_ready,
        output p_valid, p_data, p_chan
    );

    modport master (
        output a_valid, a_op, b_op,
        output x_valid, x_op, y_op,
        output p_ready,
        input  a_ready, x_ready,
        input  p_valid, p_data, p_chan
    );

endinterface

// File: rtl/mul_share_fifo2.sv
// mul_share_fifo2
// Two-entry in-order result buffer holding a product and its channel tag.
//   clk, rst_n          : clock and synchronous active-low reset
//   push                : write push_chan/push_data (ignored when full)
//   push_chan/push_data : entry to store
//   pop                 : discard the head entry (ignored when empty)
//   count               : registered occupancy, 0..2
//   head_valid          : buffer not empty
//   head_chan/head_data : oldest entry; hold their last value when empty
module mul_share_fifo2
    import mul_share_pkg::*;
#(
    parameter int N = DEFAULT_N
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             push_chan,
    input  logic [N-1:0]     push_data,
    input  logic             pop,
    output logic [CNT_W-1:0] count,
    output logic             head_valid,
    output logic             head_chan,
    output logic [N-1:0]     head_data
);

    typedef struct packed {
        logic         chan;
        logic [N-1:0] data;
    } slot_t;

    slot_t mem [DEPTH];
    logic  wr_ptr;
    logic  rd_ptr;
    logic  do_push;
    logic  do_pop;

    assign do_push = push && (count != CNT_W'(DEPTH));
    assign do_pop  = pop && (count != '0);

    // Pointer-based storage: entries never move, so a simultaneous push and
    // pop leaves the older entry at the head and the count unchanged.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= '{chan: push_chan, data: push_data};
                wr_ptr      <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    assign head_valid = (count != '0);
    assign head_chan  = mem[rd_ptr].chan;
    assign head_data  = mem[rd_ptr].data;

endmodule

// File: rtl/mul_share_sched.sv
// mul_share_sched
// Round-robin scheduler that time-shares one N x N multiplier between two
// request channels and queues the truncated products in a 2-entry buffer.
//   clk   : clock, rising edge
//   rst_n : synchronous active-low reset
//   bus   : slave side of mul_share_sched_if (A/X requests, tagged results)
module mul_share_sched
    import mul_share_pkg::*;
#(
    parameter int N = DEFAULT_N
) (
    input  logic               clk,
    input  logic               rst_n,
    mul_share_sched_if.slave   bus
);

    logic             rr_last;
    logic             grant_a;
    logic             grant_x;
    logic             space;
    logic             sel_chan;
    logic             push;
    logic             pop;
    logic [N-1:0]     op_l;
    logic [N-1:0]     op_r;
    logic [N-1:0]     product;
    logic [CNT_W-1:0] count;
    logic             head_valid;
    logic             head_chan;
    logic [N-1:0]     head_data;

    // A lone requester always wins; on a tie the channel that did not win
    // the last accept goes next.
    always_comb begin
        grant_a = bus.a_valid && (!bus.x_valid || (rr_last == CHAN_X));
        grant_x = bus.x_valid && (!bus.a_valid || (rr_last == CHAN_A));
    end

    // Space comes only from the registered count, which keeps p_ready out of
    // the ready path at the cost of one bubble after a pop from full.
    // Ready is held low during reset so no transfer appears to complete.
    assign space       = (count != CNT_W'(DEPTH));
    assign bus.a_ready = rst_n && space && grant_a;
    assign bus.x_ready = rst_n && space && grant_x;

    assign push = (bus.a_valid && bus.a_ready) || (bus.x_valid && bus.x_ready);
    assign pop  = bus.p_valid && bus.p_ready;

    // Operands are muxed before the single multiplier; the N-bit result
    // context truncates the product to its low N bits.
    always_comb begin
        sel_chan = grant_a ? CHAN_A : CHAN_X;
        op_l     = (sel_chan == CHAN_A) ? bus.a_op : bus.x_op;
        op_r     = (sel_chan == CHAN_A) ? bus.b_op : bus.y_op;
        product  = op_l * op_r;
    end

    // rr_last resets to X so that A wins the first tie after reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_last <= CHAN_X;
        end else if (push) begin
            rr_last <= sel_chan;
        end
    end

    mul_share_fifo2 #(
        .N (N)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (push),
        .push_chan  (sel_chan),
        .push_data  (product),
        .pop        (pop),
        .count      (count),
        .head_valid (head_valid),
        .head_chan  (head_chan),
        .head_data  (head_data)
    );

    assign bus.p_valid = head_valid;
    assign bus.p_chan  = head_chan;
    assign bus.p_data  = head_data;

endmodule

// File: tb/tb_mul_share_sched.sv
// tb_mul_share_sched
// Self-checking bench for mul_share_sched: directed scenarios plus a
// randomized run, all compared against a queue-based reference model.
module tb_mul_share_sched;

    localparam int N = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    mul_share_sched_if #(.N(N)) bus ();

    mul_share_sched #(.N(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit       chan;
        bit [7:0] data;
    } res_t;

    // Reference model: queued results plus the channel that last won.
    res_t exp_q[$];
    bit   m_rr = 1'b1;

    function automatic bit [7:0] trunc_mul(bit [7:0] p, bit [7:0] q);
        int unsigned full;
        full = int'(p) * int'(q);
        return full[7:0];
    endfunction

    function automatic bit exp_a_ready();
        return rst_n && (exp_q.size() < 2) && bus.a_valid && (!bus.x_valid || m_rr == 1'b1);
    endfunction

    function automatic bit exp_x_ready();
        return rst_n && (exp_q.size() < 2) && bus.x_valid && (!bus.a_valid || m_rr == 1'b0);
    endfunction

    // Advance the model across the coming rising edge using current inputs.
    task automatic model_step();
        bit acc_a;
        bit acc_x;
        bit do_pop;
        res_t r;
        if (!rst_n) begin
            exp_q.delete();
            m_rr = 1'b1;
            return;
        end
        acc_a  = exp_a_ready();
        acc_x  = exp_x_ready();
        do_pop = (exp_q.size() > 0) && bus.p_ready;
        if (do_pop) void'(exp_q.pop_front());
        if (acc_a) begin
            r.chan = 1'b0;
            r.data = trunc_mul(bus.a_op, bus.b_op);
            exp_q.push_back(r);
            m_rr = 1'b0;
        end else if (acc_x) begin
            r.chan = 1'b1;
            r.data = trunc_mul(bus.x_op, bus.y_op);
            exp_q.push_back(r);
            m_rr = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.a_valid = 1'b1; bus.a_op = 8'd3; bus.b_op = 8'd5;
        bus.x_valid = 1'b1; bus.x_op = 8'd7; bus.y_op = 8'd2;
        bus.p_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            checks++;
            if (bus.a_ready !== 1'b0 || bus.x_ready !== 1'b0) begin
                errors++;
                $display("[TB] FAIL reset_ready cycle %0d: got a=%b x=%b expected 0 0", i, bus.a_ready, bus.x_ready);
            end
            checks++;
            if (bus.p_valid !== 1'b0 || bus.p_data !== 8'd0 || bus.p_chan !== 1'b0) begin
                errors++;
                $display("[TB] FAIL reset_outputs cycle %0d: got v=%b d=%0d c=%b expected 0 0 0", i, bus.p_valid, bus.p_data, bus.p_chan);
            end
            model_step();
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if (bus.a_ready !== 1'b1 || bus.x_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_first_grant: got a=%b x=%b expected 1 0", bus.a_ready, bus.x_ready);
        end
        model_step();
        @(negedge clk);
        bus.a_valid = 1'b0; bus.x_valid = 1'b0; bus.p_ready = 1'b1;
        #1;
        checks++;
        if (bus.p_valid !== 1'b1 || bus.p_data !== 8'd15 || bus.p_chan !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_first_result: got v=%b d=%0d c=%b expected 1 15 0", bus.p_valid, bus.p_data, bus.p_chan);
        end
        model_step();
    endtask

    task automatic test_single();
        @(negedge clk);
        bus.a_valid = 1'b1; bus.a_op = 8'd3; bus.b_op = 8'd5;
        bus.x_valid = 1'b0; bus.p_ready = 1'b1;
        #1;
        checks++;
        if (bus.a_ready !== 1'b1 || bus.x_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL single_ready: got a=%b x=%b expected 1 0", bus.a_ready, bus.x_ready);
        end
        model_step();
        @(negedge clk);
        bus.a_valid = 1'b0;
        #1;
        checks++;
        if (bus.p_valid !== 1'b1 || bus.p_data !== 8'd15 || bus.p_chan !== 1'b0) begin
            errors++;
            $display("[TB] FAIL single_result: got v=%b d=%0d c=%b expected 1 15 0", bus.p_valid, bus.p_data, bus.p_chan);
        end
        model_step();
        @(negedge clk); #1;
        checks++;
        if (bus.p_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL single_drained: got p_valid=%b expected 0", bus.p_valid);
        end
        model_step();
    endtask

    task automatic test_round_robin();
        bit [7:0] want;
        // Fresh reset so A wins the first tie.
        @(negedge clk);
        rst_n = 1'b0; bus.a_valid = 1'b0; bus.x_valid = 1'b0;
        #1;
        model_step();
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            rst_n = 1'b1;
            bus.a_valid = 1'b1; bus.a_op = 8'd2; bus.b_op = 8'd3;
            bus.x_valid = 1'b1; bus.x_op = 8'd4; bus.y_op = 8'd4;
            bus.p_ready = 1'b1;
            #1;
            checks++;
            if (bus.a_ready !== (c % 2 == 0) || bus.x_ready !== (c % 2 == 1)) begin
                errors++;
                $display("[TB] FAIL rr_grant cycle %0d: got a=%b x=%b expected %b %b", c, bus.a_ready, bus.x_ready, c % 2 == 0, c % 2 == 1);
            end
            if (c > 0) begin
                want = ((c - 1) % 2 == 0) ? 8'd6 : 8'd16;
                checks++;
                if (bus.p_valid !== 1'b1 || bus.p_data !== want || bus.p_chan !== bit'((c - 1) % 2)) begin
                    errors++;
                    $display("[TB] FAIL rr_result cycle %0d: got v=%b d=%0d c=%b expected 1 %0d %0d", c, bus.p_valid, bus.p_data, bus.p_chan, want, (c - 1) % 2);
                end
            end
            model_step();
        end
        @(negedge clk);
        bus.a_valid = 1'b0; bus.x_valid = 1'b0;
        #1;
        checks++;
        if (bus.p_valid !== 1'b1 || bus.p_data !== 8'd16 || bus.p_chan !== 1'b1) begin
            errors++;
            $display("[TB] FAIL rr_last_result: got v=%b d=%0d c=%b expected 1 16 1", bus.p_valid, bus.p_data, bus.p_chan);
        end
        model_step();
    endtask

    task automatic test_backpressure();
        // Cycle-by-cycle expectations: a_ready, x_ready, p_valid, p_data, p_chan.
        bit       e_ar [7] = '{1, 1, 0, 0, 0, 0, 0};
        bit       e_xr [7] = '{0, 0, 0, 0, 1, 0, 0};
        bit       e_pv [7] = '{0, 1, 1, 1, 1, 1, 0};
        bit [7:0] e_pd [7] = '{0, 1, 1, 1, 4, 9, 0};
        bit       e_pc [7] = '{0, 0, 0, 0, 0, 1, 0};
        for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            bus.a_valid = (c < 2);
            bus.a_op = (c == 0) ? 8'd1 : 8'd2;
            bus.b_op = (c == 0) ? 8'd1 : 8'd2;
            bus.x_valid = (c >= 2 && c <= 4);
            bus.x_op = 8'd3; bus.y_op = 8'd3;
            bus.p_ready = (c >= 3);
            #1;
            checks++;
            if (bus.a_ready !== e_ar[c] || bus.x_ready !== e_xr[c]) begin
                errors++;
                $display("[TB] FAIL bp_ready cycle %0d: got a=%b x=%b expected %b %b", c, bus.a_ready, bus.x_ready, e_ar[c], e_xr[c]);
            end
            checks++;
            if (bus.p_valid !== e_pv[c] || (e_pv[c] && (bus.p_data !== e_pd[c] || bus.p_chan !== e_pc[c]))) begin
                errors++;
                $display("[TB] FAIL bp_result cycle %0d: got v=%b d=%0d c=%b expected %b %0d %b", c, bus.p_valid, bus.p_data, bus.p_chan, e_pv[c], e_pd[c], e_pc[c]);
            end
            model_step();
        end
    endtask

    task automatic test_truncation();
        @(negedge clk);
        bus.a_valid = 1'b0; bus.x_valid = 1'b1; bus.x_op = 8'd255; bus.y_op = 8'd255;
        bus.p_ready = 1'b1;
        #1;
        checks++;
        if (bus.x_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL trunc_x_ready: got %b expected 1", bus.x_ready);
        end
        model_step();
        @(negedge clk);
        bus.x_valid = 1'b0; bus.a_valid = 1'b1; bus.a_op = 8'd16; bus.b_op = 8'd16;
        #1;
        checks++;
        if (bus.p_valid !== 1'b1 || bus.p_data !== 8'h01 || bus.p_chan !== 1'b1) begin
            errors++;
            $display("[TB] FAIL trunc_255x255: got v=%b d=%0h c=%b expected 1 01 1", bus.p_valid, bus.p_data, bus.p_chan);
        end
        model_step();
        @(negedge clk);
        bus.a_valid = 1'b0;
        #1;
        checks++;
        if (bus.p_valid !== 1'b1 || bus.p_data !== 8'h00 || bus.p_chan !== 1'b0) begin
            errors++;
            $display("[TB] FAIL trunc_16x16: got v=%b d=%0h c=%b expected 1 00 0", bus.p_valid, bus.p_data, bus.p_chan);
        end
        model_step();
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        bus.p_ready = 1'b0;
        bus.x_valid = 1'b1; bus.x_op = 8'($urandom); bus.y_op = 8'($urandom);
        bus.a_valid = 1'b0;
        #1;
        model_step();
        @(negedge clk);
        bus.x_valid = 1'b0;
        bus.a_valid = 1'b1; bus.a_op = 8'($urandom); bus.b_op = 8'($urandom);
        #1;
        model_step();
        @(negedge clk);
        bus.a_valid = 1'b0;
        #1;
        checks++;
        if (bus.p_valid !== 1'b1 || bus.a_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL midrst_full: got v=%b a_ready=%b expected 1 0", bus.p_valid, bus.a_ready);
        end
        rst_n = 1'b0;
        model_step();
        @(negedge clk);
        rst_n = 1'b1;
        bus.a_valid = 1'b1; bus.a_op = 8'd7; bus.b_op = 8'd9;
        bus.x_valid = 1'b1; bus.x_op = 8'd5; bus.y_op = 8'd5;
        bus.p_ready = 1'b1;
        #1;
        checks++;
        if (bus.p_valid !== 1'b0 || bus.p_data !== 8'd0 || bus.p_chan !== 1'b0) begin
            errors++;
            $display("[TB] FAIL midrst_cleared: got v=%b d=%0d c=%b expected 0 0 0", bus.p_valid, bus.p_data, bus.p_chan);
        end
        checks++;
        if (bus.a_ready !== 1'b1 || bus.x_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL midrst_rr: got a=%b x=%b expected 1 0", bus.a_ready, bus.x_ready);
        end
        model_step();
        @(negedge clk);
        bus.a_valid = 1'b0; bus.x_valid = 1'b0;
        #1;
        checks++;
        if (bus.p_valid !== 1'b1 || bus.p_data !== 8'd63 || bus.p_chan !== 1'b0) begin
            errors++;
            $display("[TB] FAIL midrst_fresh: got v=%b d=%0d c=%b expected 1 63 0", bus.p_valid, bus.p_data, bus.p_chan);
        end
        model_step();
        @(negedge clk); #1;
        checks++;
        if (bus.p_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL midrst_no_stale: got p_valid=%b expected 0", bus.p_valid);
        end
        model_step();
    endtask

    task automatic test_random();
        bit acc_a = 1'b0;
        bit acc_x = 1'b0;
        bus.a_valid = 1'b0; bus.x_valid = 1'b0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            // Requesters hold valid and operands until accepted.
            if (!bus.a_valid || acc_a) begin
                bus.a_valid = ($urandom_range(0, 3) != 0);
                bus.a_op = 8'($urandom); bus.b_op = 8'($urandom);
            end
            if (!bus.x_valid || acc_x) begin
                bus.x_valid = ($urandom_range(0, 3) != 0);
                bus.x_op = 8'($urandom); bus.y_op = 8'($urandom);
            end
            bus.p_ready = ($urandom_range(0, 2) != 0);
            #1;
            checks++;
            if (bus.a_ready !== exp_a_ready() || bus.x_ready !== exp_x_ready()) begin
                errors++;
                $display("[TB] FAIL rand_ready cycle %0d: got a=%b x=%b expected %b %b", c, bus.a_ready, bus.x_ready, exp_a_ready(), exp_x_ready());
            end
            checks++;
            if (bus.p_valid !== (exp_q.size() > 0)) begin
                errors++;
                $display("[TB] FAIL rand_p_valid cycle %0d: got %b expected %b", c, bus.p_valid, exp_q.size() > 0);
            end else if (exp_q.size() > 0) begin
                checks++;
                if (bus.p_data !== exp_q[0].data || bus.p_chan !== exp_q[0].chan) begin
                    errors++;
                    $display("[TB] FAIL rand_head cycle %0d: got d=%0d c=%b expected %0d %b", c, bus.p_data, bus.p_chan, exp_q[0].data, exp_q[0].chan);
                end
            end
            acc_a = exp_a_ready();
            acc_x = exp_x_ready();
            model_step();
        end
    endtask

    initial begin
        $display("[TB] mul_share_sched bench start");
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_truncation();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mul_share_sched.md
# mul_share_sched

Two-channel scheduler feeding one shared N×N multiplier. Channel A (operands a/b) and channel X (operands x/y) each present requests over a valid/ready handshake. A round-robin arbiter grants at most one request per cycle, drives the operand mux into the single multiplier, and registers the low N bits of the product, tagged with the source channel, into a 2-entry output buffer. The block sits upstream of the product consumer and replaces two dedicated multipliers with one time-shared multiplier.

## Interface
- N, default 8: operand and result width.
- clk  in  1: clock, all logic on rising edge.
- rst_n  in  1: synchronous active-low reset.
- a_valid  in  1: channel A request valid.
- a_ready  out  1: channel A request accepted this cycle when high together with a_valid.
- a_op, b_op  in  N: channel A operands.
- x_valid  in  1: channel X request valid.
- x_ready  out  1: channel X request accepted this cycle when high together with x_valid.
- x_op, y_op  in  N: channel X operands.
- p_valid  out  1: result available at buffer head.
- p_ready  in  1: consumer accepts head result.
- p_data  out  N: product, low N bits.
- p_chan  out  1: source channel of p_data, 0 = A, 1 = X.

## Operation
- Reset (rst_n low at a rising edge): buffer count = 0, p_valid = 0, p_data = 0, p_chan = 0, rr_last = 1 (so A wins the first tie). Reset has priority over every other event; an in-flight transfer in the reset cycle is discarded.
- space = (count != 2), taken from the registered count only; no combinational path from p_ready to a_ready/x_ready.
- Grant: only A valid -> A; only X valid -> X; both valid -> the channel that is not rr_last. a_ready = space & grant_A; x_ready = space & grant_X. Ready for one channel depends on the other channel's valid; no ready is asserted when neither is valid.
- Accept: when a grant fires with space, product = (sel ? a_op*b_op : x_op*y_op)[N-1:0], pushed with its channel tag; rr_last updates to the accepted channel. rr_last is unchanged in cycles without an accept.
- Buffer: 2-entry FIFO, in-order. Pop when p_valid & p_ready. Push and pop in the same cycle: count unchanged, entry order preserved. Count 2: no accept, pop still allowed. Count 0: p_valid = 0; p_data/p_chan hold their last value and are don't-care.
- Requesters must hold valid and operands stable until accepted; the block does not check this.
- Arithmetic: unsigned, product truncated to N bits with no saturation or overflow flag.

## Timing
- Latency: accept at edge t -> p_valid high after edge t (visible in cycle t+1) with count 0 -> 1.
- Throughput: one result per cycle while p_ready stays high. With p_ready low, at most two accepts occur, then a_ready = x_ready = 0 until a pop. After the first pop from full, ready reasserts the next cycle (one bubble).
- Fairness: with both channels continuously valid and the buffer draining, grants alternate A, X, A, X …
- Multiplier is a single-cycle combinational path between the operand mux and the buffer write port.

## Structure
- Package mul_share_pkg: CHAN_A = 1'b0, CHAN_X = 1'b1, DEPTH = 2, entry typedef {chan, data[N-1:0]}.
- Sub-module mul_share_fifo2: the 2-entry buffer with count, push, pop and head outputs. Arbiter, operand mux and multiplier stay in the top module.

## Test plan
- Reset: hold rst_n low for 3 cycles with both valids high -> no ready, p_valid = 0, p_data = 0, p_chan = 0; after release with both valid, the first grant goes to A.
- Single channel: A sends 3×5, p_ready = 1 -> a_ready in cycle 0, next cycle p_valid = 1, p_data = 15, p_chan = 0.
- Round-robin: A sends 2×3 and X sends 4×4, both held valid, p_ready = 1 -> results 6 (A), 16 (X), 6 (A), 16 (X) on consecutive cycles.
- Backpressure: p_ready = 0 with A sending 1×1 then 2×2, and X sending 3×3 -> two accepts, then readies low; raise p_ready -> results 1, then 4, delivered in order; X accepted the cycle after the first pop.
- Truncation at N = 8: X sends 255×255 -> p_data = 8'h01; A sends 16×16 -> p_data = 0.
- Reset mid-stream: buffer holds 2 entries and rst_n is pulsed low for one cycle -> count = 0 and p_valid = 0 next cycle; rr_last = 1 and no stale result appears.
